// File: rtl/countdown_timer.sv
// Countdown timer: loads a preset on start, decrements once per tick while
// running, and signals expiry with a level (expired) and a one-cycle pulse (done_p).
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | not counting; tout holds, waits for start
// RUN     | counting down on each tick
// PAUSED  | count frozen while pause is high
// DONE    | count reached zero; expired high until restart
module countdown_timer #(
    parameter logic [7:0] WARN_LEVEL = 8'd4
) (
    input  logic       clk,
    input  logic       r_n,
    input  logic       tick,
    input  logic       start,
    input  logic [7:0] preset,
    input  logic       pause,
    input  logic       clear,
    output logic [7:0] tout,
    output logic       running,
    output logic       expired,
    output logic       done_p,
    output logic       warn
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] tout_q, tout_d;
    logic       done_p_q, done_p_d;

    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            state_q  <= IDLE;
            tout_q   <= 8'd0;
            done_p_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tout_q   <= tout_d;
            done_p_q <= done_p_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tout_d   = tout_q;
        done_p_d = 1'b0;
        if (clear) begin
            state_d = IDLE;
            tout_d  = 8'd0;
        end else if (start) begin
            tout_d = preset;
            if (preset != 8'd0) begin
                state_d = RUN;
            end else begin
                state_d  = DONE;
                done_p_d = 1'b1;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (pause) begin
                        state_d = PAUSED;
                    end else if (tick) begin
                        // Treat a stray zero count in RUN as expiry so tout never wraps.
                        if (tout_q > 8'd1) begin
                            tout_d = tout_q - 8'd1;
                        end else begin
                            tout_d   = 8'd0;
                            state_d  = DONE;
                            done_p_d = 1'b1;
                        end
                    end
                end
                PAUSED: begin
                    if (!pause) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    tout_d = 8'd0;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    assign tout    = tout_q;
    assign done_p  = done_p_q;
    assign running = (state_q == RUN) || (state_q == PAUSED);
    assign expired = (state_q == DONE);
    assign warn    = running && (tout_q != 8'd0) && (tout_q <= WARN_LEVEL);

endmodule
